// File: rtl/slide_write_sequencer.sv
// Slide-up write sequencer: rotates source beats by shift_amount mod VLANE_NUM,
// merges wrapped lanes with the previous beat and issues masked write beats.
module slide_write_sequencer #(
  parameter  int VLANE_NUM         = 8,
  parameter  int VREG_LOC_PER_LANE = 8,
  parameter  int DATA_W            = 32,
  localparam int MAXE              = VREG_LOC_PER_LANE * 32 * VLANE_NUM,
  localparam int SA_W              = $clog2(MAXE),
  localparam int LW                = $clog2(VLANE_NUM),
  localparam int BW                = SA_W - LW
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        start_i,
  input  logic [SA_W-1:0]             shift_amount_i,
  input  logic [SA_W:0]               vl_i,
  output logic                        busy_o,
  output logic                        done_o,
  input  logic                        src_valid_i,
  output logic                        src_ready_o,
  input  logic [VLANE_NUM*DATA_W-1:0] src_data_i,
  output logic                        dst_valid_o,
  input  logic                        dst_ready_i,
  output logic [VLANE_NUM*DATA_W-1:0] dst_data_o,
  output logic [VLANE_NUM-1:0]        dst_mask_o,
  output logic [BW-1:0]               dst_beat_o
);
  localparam int VW = VLANE_NUM * DATA_W;

  typedef enum logic [1:0] {IDLE, STREAM, FLUSH, FIN} state_e;

  state_e               state_q, state_d;
  logic [SA_W-1:0]      s_q, s_d;
  logic [SA_W:0]        vl_q, vl_d;
  logic [BW:0]          nsrc_q, nsrc_d, ndst_q, ndst_d, cnt_q, cnt_d;
  logic [VW-1:0]        h_q, h_d, data_q, data_d;
  logic [VLANE_NUM-1:0] mask_q, mask_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic                 dvalid_q, dvalid_d, busy_q, busy_d, done_q, done_d;

  logic [SA_W:0]        s_ext, span_up, vl_m1;
  logic [BW:0]          cfg_nsrc, cfg_ndst, q_cur, stream_b, flush_b;
  logic [LW-1:0]        r_cur;
  logic [VW-1:0]        stream_data, flush_data;
  logic                 src_fire, dst_free;

  function automatic logic [LW-1:0] src_lane(input int j, input logic [LW-1:0] r);
    return LW'(j) - r;
  endfunction

  // A lane is written only when its element index lies in [s, vl).
  function automatic logic [VLANE_NUM-1:0] beat_mask(input logic [BW:0]     b,
                                                     input logic [SA_W-1:0] s,
                                                     input logic [SA_W:0]   vl);
    logic [VLANE_NUM-1:0] m;
    logic [SA_W:0]        e;
    m = '0;
    for (int j = 0; j < VLANE_NUM; j++) begin
      e    = {b, LW'(j)};
      m[j] = ({1'b0, s} <= e) && (e < vl);
    end
    return m;
  endfunction

  always_comb begin
    s_ext   = {1'b0, shift_amount_i};
    span_up = vl_i - s_ext + (SA_W+1)'(VLANE_NUM - 1);
    vl_m1   = vl_i - (SA_W+1)'(1);
    if (vl_i <= s_ext) begin
      cfg_nsrc = '0;
      cfg_ndst = '0;
    end else begin
      cfg_nsrc = span_up[SA_W:LW];
      cfg_ndst = vl_m1[SA_W:LW] - {1'b0, shift_amount_i[SA_W-1:LW]} + (BW+1)'(1);
    end
  end

  always_comb begin
    r_cur       = s_q[LW-1:0];
    q_cur       = {1'b0, s_q[SA_W-1:LW]};
    stream_b    = q_cur + cnt_q;
    flush_b     = q_cur + nsrc_q;
    stream_data = '0;
    flush_data  = '0;
    for (int j = 0; j < VLANE_NUM; j++) begin
      if (LW'(j) >= r_cur) begin
        stream_data[j*DATA_W +: DATA_W] = src_data_i[int'(src_lane(j, r_cur))*DATA_W +: DATA_W];
      end else begin
        stream_data[j*DATA_W +: DATA_W] = h_q[int'(src_lane(j, r_cur))*DATA_W +: DATA_W];
        flush_data[j*DATA_W +: DATA_W]  = h_q[int'(src_lane(j, r_cur))*DATA_W +: DATA_W];
      end
    end
  end

  assign dst_free    = !dvalid_q || dst_ready_i;
  assign src_ready_o = (state_q == STREAM) && (cnt_q < nsrc_q) && dst_free;
  assign src_fire    = src_ready_o && src_valid_i;

  always_comb begin
    state_d  = state_q;
    s_d      = s_q;
    vl_d     = vl_q;
    nsrc_d   = nsrc_q;
    ndst_d   = ndst_q;
    cnt_d    = cnt_q;
    h_d      = h_q;
    data_d   = data_q;
    mask_d   = mask_q;
    beat_d   = beat_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    dvalid_d = dvalid_q && !dst_ready_i;
    unique case (state_q)
      IDLE: begin
        if (start_i) begin
          s_d     = shift_amount_i;
          vl_d    = vl_i;
          nsrc_d  = cfg_nsrc;
          ndst_d  = cfg_ndst;
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = (cfg_nsrc == '0) ? FIN : STREAM;
        end
      end
      STREAM: begin
        if (src_fire) begin
          data_d   = stream_data;
          mask_d   = beat_mask(stream_b, s_q, vl_q);
          beat_d   = stream_b[BW-1:0];
          dvalid_d = 1'b1;
          h_d      = src_data_i;
          cnt_d    = cnt_q + (BW+1)'(1);
          // The tail of the last source beat spills into one extra beat when D = S+1.
          if (cnt_q + (BW+1)'(1) == nsrc_q) begin
            state_d = (ndst_q == nsrc_q + (BW+1)'(1)) ? FLUSH : FIN;
          end
        end
      end
      FLUSH: begin
        if (dst_free) begin
          data_d   = flush_data;
          mask_d   = beat_mask(flush_b, s_q, vl_q);
          beat_d   = flush_b[BW-1:0];
          dvalid_d = 1'b1;
          state_d  = FIN;
        end
      end
      FIN: begin
        if (!dvalid_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      s_q      <= '0;
      vl_q     <= '0;
      nsrc_q   <= '0;
      ndst_q   <= '0;
      cnt_q    <= '0;
      h_q      <= '0;
      data_q   <= '0;
      mask_q   <= '0;
      beat_q   <= '0;
      dvalid_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      s_q      <= s_d;
      vl_q     <= vl_d;
      nsrc_q   <= nsrc_d;
      ndst_q   <= ndst_d;
      cnt_q    <= cnt_d;
      h_q      <= h_d;
      data_q   <= data_d;
      mask_q   <= mask_d;
      beat_q   <= beat_d;
      dvalid_q <= dvalid_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign dst_valid_o = dvalid_q;
  assign dst_data_o  = data_q;
  assign dst_mask_o  = mask_q;
  assign dst_beat_o  = beat_q;

endmodule

// File: tb/tb_slide_write_sequencer.sv
// Directed bench for slide_write_sequencer: expected write beats are queued when
// a slide is launched and an independent monitor compares each consumed beat.
module tb_slide_write_sequencer;
  localparam int N    = 8;
  localparam int DW   = 32;
  localparam int SA_W = 11;
  localparam int BW   = 8;
  localparam int VW   = N * DW;

  typedef struct packed {
    logic [BW-1:0] beat;
    logic [N-1:0]  mask;
    logic [VW-1:0] data;
  } exp_t;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            start_i;
  logic [SA_W-1:0] shift_amount_i;
  logic [SA_W:0]   vl_i;
  logic            busy_o, done_o;
  logic            src_valid_i, src_ready_o;
  logic [VW-1:0]   src_data_i;
  logic            dst_valid_o, dst_ready_i;
  logic [VW-1:0]   dst_data_o;
  logic [N-1:0]    dst_mask_o;
  logic [BW-1:0]   dst_beat_o;

  exp_t          exp_q[$];
  logic [VW-1:0] src_q[$];
  int tests = 0, fails = 0, cyc = 0;
  int done_cnt = 0, done_cyc = 0, beats_seen = 0, src_accepts = 0, start_cyc = 0;
  bit src_fire;

  slide_write_sequencer #(.VLANE_NUM(N), .VREG_LOC_PER_LANE(8), .DATA_W(DW)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i), .shift_amount_i(shift_amount_i),
    .vl_i(vl_i), .busy_o(busy_o), .done_o(done_o), .src_valid_i(src_valid_i),
    .src_ready_o(src_ready_o), .src_data_i(src_data_i), .dst_valid_o(dst_valid_o),
    .dst_ready_i(dst_ready_i), .dst_data_o(dst_data_o), .dst_mask_o(dst_mask_o),
    .dst_beat_o(dst_beat_o)
  );

  always #5 clk_i = ~clk_i;
  always @(posedge clk_i) cyc++;

  function automatic logic [VW-1:0] pk(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
    return {a7, a6, a5, a4, a3, a2, a1, a0};
  endfunction

  function automatic logic [VW-1:0] seq(input logic [31:0] base);
    return pk(base, base + 1, base + 2, base + 3, base + 4, base + 5, base + 6, base + 7);
  endfunction

  function automatic logic [VW-1:0] lane_bits(input logic [N-1:0] m);
    logic [VW-1:0] b;
    b = '0;
    for (int j = 0; j < N; j++) if (m[j]) b[j*DW +: DW] = '1;
    return b;
  endfunction

  task automatic checkOutput(input string name, input logic [VW-1:0] act, input logic [VW-1:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic pushExp(input logic [BW-1:0] beat, input logic [N-1:0] mask, input logic [VW-1:0] data);
    exp_t e;
    e.beat = beat;
    e.mask = mask;
    e.data = data;
    exp_q.push_back(e);
  endtask

  task automatic applyStimulus(input int s, input int vl);
    @(posedge clk_i); #2;
    shift_amount_i = SA_W'(s);
    vl_i           = (SA_W+1)'(vl);
    start_i        = 1'b1;
    start_cyc      = cyc;
    @(posedge clk_i); #2;
    start_i = 1'b0;
    checkOutput("busy_after_start", busy_o, 1);
  endtask

  task automatic waitDone(input string name);
    int base;
    bit got;
    base = done_cnt;
    got  = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk_i); #1;
      if (done_cnt != base) got = 1'b1;
    end
    checkOutput({name, "_done_seen"}, got, 1);
    @(negedge clk_i); #1;
    checkOutput({name, "_done_single"}, done_o, 0);
    checkOutput({name, "_busy_idle"}, busy_o, 0);
  endtask

  // Source driver: presents queued beats and retires one per handshake.
  initial begin
    src_valid_i = 1'b0;
    src_data_i  = '0;
    forever begin
      @(negedge clk_i);
      src_fire = src_valid_i && src_ready_o && rst_i;
      @(posedge clk_i); #1;
      if (src_fire && src_q.size() > 0) begin
        void'(src_q.pop_front());
        src_accepts++;
      end
      if (src_q.size() > 0) begin
        src_valid_i = 1'b1;
        src_data_i  = src_q[0];
      end else begin
        src_valid_i = 1'b0;
      end
    end
  end

  // Monitor: every consumed write beat is matched against the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (rst_i) begin
        if (done_o) begin
          done_cnt++;
          done_cyc = cyc;
        end
        if (dst_valid_o && dst_ready_i) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_beat", dst_beat_o, '1);
          end else begin
            e = exp_q.pop_front();
            checkOutput("beat_index", dst_beat_o, e.beat);
            checkOutput("beat_mask", dst_mask_o, e.mask);
            checkOutput("beat_data", dst_data_o & lane_bits(e.mask), e.data & lane_bits(e.mask));
          end
        end
      end
    end
  end

  initial begin
    int  base, rel_cyc, done_base;
    bit  got;
    rst_i = 1'b0; start_i = 1'b0; shift_amount_i = '0; vl_i = '0; dst_ready_i = 1'b1;
    repeat (3) @(posedge clk_i);
    #2;
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_done", done_o, 0);
    checkOutput("rst_dst_valid", dst_valid_o, 0);
    checkOutput("rst_src_ready", src_ready_o, 0);
    checkOutput("rst_mask", dst_mask_o, 0);
    checkOutput("rst_beat", dst_beat_o, 0);
    @(posedge clk_i); #2;
    rst_i = 1'b1;

    // s=3, vl=16: two beats, no flush
    src_accepts = 0;
    src_q.push_back(seq(32'h10));
    src_q.push_back(seq(32'h20));
    pushExp(0, 8'hF8, pk(0, 0, 0, 'h10, 'h11, 'h12, 'h13, 'h14));
    pushExp(1, 8'hFF, pk('h15, 'h16, 'h17, 'h20, 'h21, 'h22, 'h23, 'h24));
    applyStimulus(3, 16);
    waitDone("t1");
    checkOutput("t1_sb_empty", exp_q.size(), 0);
    checkOutput("t1_accepts", src_accepts, 2);

    // s=6, vl=11: one source beat, wrapped tail issued from FLUSH
    src_accepts = 0;
    src_q.push_back(seq(32'h0));
    src_q.push_back(seq(32'h8));
    pushExp(0, 8'hC0, pk(0, 0, 0, 0, 0, 0, 0, 1));
    pushExp(1, 8'h07, pk(2, 3, 4, 0, 0, 0, 0, 0));
    applyStimulus(6, 11);
    waitDone("t2");
    checkOutput("t2_sb_empty", exp_q.size(), 0);
    checkOutput("t2_accepts", src_accepts, 1);
    src_q.delete();

    // s=10, vl=20: starts at beat 1
    src_accepts = 0;
    src_q.push_back(seq(32'h30));
    src_q.push_back(seq(32'h40));
    pushExp(1, 8'hFC, pk(0, 0, 'h30, 'h31, 'h32, 'h33, 'h34, 'h35));
    pushExp(2, 8'h0F, pk('h36, 'h37, 'h40, 'h41, 0, 0, 0, 0));
    applyStimulus(10, 20);
    waitDone("t3");
    checkOutput("t3_sb_empty", exp_q.size(), 0);
    checkOutput("t3_accepts", src_accepts, 2);

    // s=20, vl=16: empty slide
    src_accepts = 0;
    base = beats_seen;
    src_q.push_back(seq(32'h99));
    applyStimulus(20, 16);
    waitDone("t4");
    checkOutput("t4_done_latency", done_cyc - start_cyc, 2);
    checkOutput("t4_no_beats", beats_seen - base, 0);
    checkOutput("t4_accepts", src_accepts, 0);
    src_q.delete();

    // s=0, vl=32 with a 3-cycle dst stall after the first beat
    src_accepts = 0;
    for (int k = 0; k < 4; k++) begin
      src_q.push_back(seq(32'h50 + 32'(8 * k)));
      pushExp(BW'(k), 8'hFF, seq(32'h50 + 32'(8 * k)));
    end
    applyStimulus(0, 32);
    base = beats_seen;
    got  = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_i); #1;
      if (beats_seen > base) got = 1'b1;
    end
    checkOutput("t5_first_beat", got, 1);
    @(posedge clk_i); #2;
    dst_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk_i);
      checkOutput("t5_hold_valid", dst_valid_o, 1);
      checkOutput("t5_hold_beat", dst_beat_o, 1);
      checkOutput("t5_hold_mask", dst_mask_o, 8'hFF);
      checkOutput("t5_hold_data", dst_data_o, seq(32'h58));
      checkOutput("t5_hold_src_ready", src_ready_o, 0);
    end
    @(posedge clk_i); #2;
    dst_ready_i = 1'b1;
    rel_cyc = cyc;
    waitDone("t5");
    checkOutput("t5_throughput", done_cyc - rel_cyc, 4);
    checkOutput("t5_sb_empty", exp_q.size(), 0);
    checkOutput("t5_accepts", src_accepts, 4);

    // asynchronous reset while a beat is stalled in the output register
    dst_ready_i = 1'b0;
    for (int k = 0; k < 4; k++) src_q.push_back(seq(32'h60 + 32'(8 * k)));
    applyStimulus(0, 32);
    got = 1'b0;
    for (int i = 0; i < 50 && !got; i++) begin
      @(negedge clk_i); #1;
      if (dst_valid_o) got = 1'b1;
    end
    checkOutput("t6_valid_before_reset", got, 1);
    done_base = done_cnt;
    rst_i = 1'b0;
    #1;
    checkOutput("t6_async_busy", busy_o, 0);
    checkOutput("t6_async_dst_valid", dst_valid_o, 0);
    checkOutput("t6_async_src_ready", src_ready_o, 0);
    src_q.delete();
    exp_q.delete();
    repeat (2) @(posedge clk_i);
    #2;
    rst_i       = 1'b1;
    dst_ready_i = 1'b1;
    src_accepts = 0;
    src_q.push_back(seq(32'h70));
    pushExp(0, 8'hFF, seq(32'h70));
    applyStimulus(0, 8);
    waitDone("t6");
    checkOutput("t6_single_done", done_cnt - done_base, 1);
    checkOutput("t6_sb_empty", exp_q.size(), 0);
    checkOutput("t6_accepts", src_accepts, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/slide_write_sequencer.md
Name: slide_write_sequencer

Overview:
- Destination-side slide-up engine in the vector control unit.
- Accepts source vector beats (one element per lane per beat) and rotates them across lanes by shift_amount mod VLANE_NUM.
- Merges each beat with the previously accepted beat for lanes that wrap around.
- Issues masked destination-register write beats; lanes outside the range [shift_amount, vl) are never written.

Parameters:
- VLANE_NUM, 8, number of lanes; power of two, >= 2.
- VREG_LOC_PER_LANE, 8, register locations per lane; maximum elements MAXE = VREG_LOC_PER_LANE*32*VLANE_NUM.
- DATA_W, 32, element width per lane.
- Derived: SA_W = clog2(MAXE); LW = clog2(VLANE_NUM); BW = SA_W - LW.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_i  in  1  reset; asynchronous, active-low.
- start_i  in  1  start pulse; sampled only in IDLE.
- shift_amount_i  in  SA_W  slide offset s, in elements.
- vl_i  in  SA_W+1  vector length in elements.
- busy_o  out  1  high from the cycle after an accepted start until done.
- done_o  out  1  one-cycle completion pulse.
- src_valid_i  in  1  source beat valid.
- src_ready_o  out  1  source beat accepted when valid && ready.
- src_data_i  in  VLANE_NUM*DATA_W  source beat; lane j occupies bits [j*DATA_W +: DATA_W].
- dst_valid_o  out  1  write beat valid.
- dst_ready_i  in  1  write beat consumed when valid && ready.
- dst_data_o  out  VLANE_NUM*DATA_W  write data.
- dst_mask_o  out  VLANE_NUM  per-lane write enable.
- dst_beat_o  out  BW  destination beat index.

Behaviour:
- Element mapping: element e sits in beat e>>LW, lane e mod VLANE_NUM.
- Configuration at start: s, vl are captured. Derived values:
  - q = s>>LW, r = s mod VLANE_NUM
  - S = ceil((vl-s)/VLANE_NUM) source beats
  - last = (vl-1)>>LW, D = last-q+1 destination beats
  - If vl <= s, then S = D = 0.
- Reset: all outputs 0, FSM in IDLE, hold register H cleared.
- States: IDLE, STREAM, FLUSH, FIN.
- IDLE:
  - start_i=1 captures config and moves to STREAM; if S=0, moves to FIN instead.
  - start_i while not IDLE is ignored.
- STREAM:
  - src_ready_o = (src beats accepted < S) && (!dst_valid_o || dst_ready_i).
  - Accepting source beat k (k=0..S-1) loads the output register on the same edge, so dst_valid_o rises the next cycle (latency 1). Contents:
    - dst_beat_o = q+k.
    - Lane j >= r: data from src lane j-r.
    - Lane j < r: data from H lane j-r+VLANE_NUM. For k=0 these lanes are masked off.
  - H <= src beat on every accept.
  - After the output of beat S-1 is loaded: go to FLUSH if D = S+1, else FIN.
- FLUSH:
  - Once the output register is free, load beat q+S from H only.
  - Only lanes j < r can be enabled.
  - Then go to FIN.
- Mask rule, applied to every beat b: dst_mask_o[j] = (s <= b*VLANE_NUM+j < vl).
  - Beats whose computed mask is all-zero are still issued only if they are counted in D.
- FIN: wait until the output register drains (no pending dst_valid_o), then pulse done_o for 1 cycle and go to IDLE. busy_o drops in the same cycle as done_o.
- Output stability: while dst_valid_o && !dst_ready_i, dst_data_o, dst_mask_o and dst_beat_o hold, and src_ready_o=0.
- Simultaneous events: a dst handshake and a new load in the same cycle are allowed, giving back-to-back beats at full throughput.
- Widths: all beat arithmetic is unsigned, BW+1 bits internally. vl=MAXE is legal; last = 2^BW-1.
- Reset mid-operation: asynchronous clear to the reset state. A partially issued slide is abandoned, and no done_o pulse is produced.

Test Plan:
- s=3, vl=16, VLANE_NUM=8, src0 lane i=0x10+i, src1 lane i=0x20+i:
  - Beat 0: mask 0xF8, lanes 3..7 = 0x10..0x14.
  - Beat 1: mask 0xFF, lanes 0..2 = 0x15..0x17, lanes 3..7 = 0x20..0x24.
  - done_o follows; no flush.
- s=6, vl=11 (flush), src0 lane i=i:
  - Beat 0: mask 0xC0, lanes 6,7 = 0,1.
  - Beat 1: from FLUSH, mask 0x07, lanes 0..2 = 2,3,4.
  - src_ready_o drops after 1 accept.
- s=10, vl=20:
  - Beat 1: mask 0xFC.
  - Beat 2: mask 0x0F, lanes 0..1 = src0 lanes 6..7, lanes 2..3 = src1 lanes 0..1.
- s=20, vl=16: no src accept, no dst beat; done_o pulses 2 cycles after start.
- Backpressure: dst_ready_i=0 for 3 cycles mid-stream, then released:
  - Outputs frozen and src_ready_o=0 for those 3 cycles.
  - Full throughput resumes, with no beat lost or duplicated.
- Async rst_i low during STREAM:
  - busy_o, dst_valid_o, src_ready_o go to 0 without a clock edge.
  - After release, a new start with s=0, vl=8 yields a single beat with mask 0xFF equal to src0.
